// File: rtl/sdc_defs_pkg.sv
// SD-controller register map, event status bit positions and COMMAND field layout.
// Shared by the Wishbone register model and sd_fsm.
package sdc_defs_pkg;

   localparam logic [7:0] SDC_ARGUMENT          = 8'h00;
   localparam logic [7:0] SDC_COMMAND           = 8'h04;
   localparam logic [7:0] SDC_RESPONSE_0        = 8'h08;
   localparam logic [7:0] SDC_RESPONSE_1        = 8'h0C;
   localparam logic [7:0] SDC_RESPONSE_2        = 8'h10;
   localparam logic [7:0] SDC_RESPONSE_3        = 8'h14;
   localparam logic [7:0] SDC_DATA_TIMEOUT      = 8'h18;
   localparam logic [7:0] SDC_CONTROL           = 8'h1C;
   localparam logic [7:0] SDC_CMD_TIMEOUT       = 8'h20;
   localparam logic [7:0] SDC_CLOCK_DIVIDER     = 8'h24;
   localparam logic [7:0] SDC_SOFT_RESET        = 8'h28;
   localparam logic [7:0] SDC_VOLTAGE           = 8'h2C;
   localparam logic [7:0] SDC_CAPABILITIES      = 8'h30;
   localparam logic [7:0] SDC_CMD_EVENT_STATUS  = 8'h34;
   localparam logic [7:0] SDC_CMD_EVENT_ENABLE  = 8'h38;
   localparam logic [7:0] SDC_DATA_EVENT_STATUS = 8'h3C;
   localparam logic [7:0] SDC_DATA_EVENT_ENABLE = 8'h40;
   localparam logic [7:0] SDC_BLOCK_SIZE        = 8'h44;
   localparam logic [7:0] SDC_BLOCK_COUNT       = 8'h48;
   localparam logic [7:0] SDC_DATA_XFER_ADDRESS = 8'h60;

   localparam int CMD_INDEX_LSB   = 7;
   localparam int CMD_INDEX_MSB   = 12;
   localparam int CMD_XFER_LSB    = 4;
   localparam int CMD_XFER_MSB    = 5;
   localparam int MMC_RSP_PRESENT = 0;
   localparam int MMC_RSP_136     = 1;
   localparam int MMC_RSP_CRC     = 2;
   localparam int MMC_RSP_BUSY    = 3;

   localparam int INT_CMD_CC   = 0;
   localparam int INT_CMD_EI   = 1;
   localparam int INT_CMD_CTE  = 2;
   localparam int INT_CMD_CCRC = 3;
   localparam int INT_CMD_CIE  = 4;
   localparam int INT_DATA_CC  = 0;
   localparam int INT_DATA_EI  = 1;

   localparam logic [31:0] MASK_32 = 32'hFFFF_FFFF;
   localparam logic [31:0] MASK_24 = 32'h00FF_FFFF;
   localparam logic [31:0] MASK_16 = 32'h0000_FFFF;
   localparam logic [31:0] MASK_13 = 32'h0000_1FFF;
   localparam logic [31:0] MASK_12 = 32'h0000_0FFF;
   localparam logic [31:0] MASK_8  = 32'h0000_00FF;
   localparam logic [31:0] MASK_5  = 32'h0000_001F;
   localparam logic [31:0] MASK_1  = 32'h0000_0001;

   typedef enum logic [1:0] {
      ENG_IDLE = 2'd0,
      ENG_BUSY = 2'd1,
      ENG_DONE = 2'd2
   } eng_state_e;

   function automatic logic [31:0] reg_write(input logic [31:0] old_v, input logic [31:0] wdat,
                                             input logic [3:0] sel, input logic [31:0] mask);
      logic [31:0] merged;
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : old_v[8*b +: 8];
      end
      return merged & mask;
   endfunction

endpackage

// File: rtl/sdc_cmd_engine.sv
// Timed command engine: samples the command at launch, counts CMD_LATENCY cycles,
// then presents a one-cycle completion strobe with the modelled result.
module sdc_cmd_engine
   import sdc_defs_pkg::*;
#(
   parameter logic [15:0] CMD_LATENCY = 16'd64,
   parameter logic [31:0] RSP_PATTERN = 32'h0000_0900
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        soft_rst_i,
   input  logic        launch_i,
   input  logic [31:0] arg_i,
   input  logic [5:0]  index_i,
   input  logic [1:0]  xfer_i,
   input  logic [1:0]  rsp_i,
   input  logic [23:0] cmd_timeout_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        timeout_o,
   output logic        set_resp0_o,
   output logic        set_resp_long_o,
   output logic        data_evt_o,
   output logic [31:0] resp0_o,
   output logic [31:0] resp1_o
);
   localparam logic [23:0] LATENCY_24 = {8'd0, CMD_LATENCY};

   eng_state_e  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] arg_q, arg_d;
   logic [5:0]  index_q, index_d;
   logic [1:0]  xfer_q, xfer_d;
   logic [1:0]  rsp_q, rsp_d;

   // The counter reaches zero on the edge that enters DONE, so completion lands at launch + CMD_LATENCY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      arg_d   = arg_q;
      index_d = index_q;
      xfer_d  = xfer_q;
      rsp_d   = rsp_q;
      if (soft_rst_i) begin
         state_d = ENG_IDLE;
      end else begin
         case (state_q)
            ENG_IDLE: begin
               if (launch_i) begin
                  state_d = ENG_BUSY;
                  cnt_d   = CMD_LATENCY - 16'd1;
                  arg_d   = arg_i;
                  index_d = index_i;
                  xfer_d  = xfer_i;
                  rsp_d   = rsp_i;
               end else begin
                  state_d = ENG_IDLE;
               end
            end
            ENG_BUSY: begin
               cnt_d   = cnt_q - 16'd1;
               state_d = (cnt_q == 16'd1) ? ENG_DONE : ENG_BUSY;
            end
            ENG_DONE: state_d = ENG_IDLE;
            default:  state_d = ENG_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o          = (state_q != ENG_IDLE);
      done_o          = (state_q == ENG_DONE) && !soft_rst_i;
      timeout_o       = rsp_q[MMC_RSP_PRESENT] && (cmd_timeout_i < LATENCY_24);
      set_resp0_o     = rsp_q[MMC_RSP_PRESENT] && !timeout_o;
      set_resp_long_o = rsp_q[MMC_RSP_136] && !timeout_o;
      data_evt_o      = (xfer_q != 2'd0);
      resp0_o         = RSP_PATTERN ^ arg_q;
      resp1_o         = {26'd0, index_q};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ENG_IDLE;
         cnt_q   <= 16'd0;
         arg_q   <= 32'd0;
         index_q <= 6'd0;
         xfer_q  <= 2'd0;
         rsp_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         arg_q   <= arg_d;
         index_q <= index_d;
         xfer_q  <= xfer_d;
         rsp_q   <= rsp_d;
      end
   end

endmodule

// File: rtl/sdc_wb_regs.sv
// Wishbone classic responder modelling the SD-controller register map, command engine
// and event/IRQ status, so sd_fsm can run without a real card.
module sdc_wb_regs
   import sdc_defs_pkg::*;
#(
   parameter logic [15:0] CMD_LATENCY   = 16'd64,
   parameter logic [31:0] RSP_PATTERN   = 32'h0000_0900,
   parameter logic [31:0] VOLTAGE_VALUE = 32'd3300,
   parameter logic [31:0] CAPS_VALUE    = 32'd0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic [7:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic        cmd_busy_o,
   output logic        int_cmd_o,
   output logic        int_data_o
);
   logic        ack_q, ack_d, dat_sel_s;
   logic [31:0] dat_q, dat_d, rdata_s;
   logic        req_s, wr_s, launch_s, cmd_clr_s, data_clr_s;
   logic [31:0] argument_q, argument_d, command_q, command_d, data_timeout_q, data_timeout_d;
   logic [31:0] control_q, control_d, cmd_timeout_q, cmd_timeout_d, clock_div_q, clock_div_d;
   logic [31:0] soft_reset_q, soft_reset_d, cmd_enable_q, cmd_enable_d, data_enable_q, data_enable_d;
   logic [31:0] block_size_q, block_size_d, block_count_q, block_count_d, xfer_addr_q, xfer_addr_d;
   logic [31:0] resp0_q, resp0_d, resp1_q, resp1_d, resp2_q, resp2_d, resp3_q, resp3_d;
   logic [4:0]  cmd_status_q, cmd_status_d, data_status_q, data_status_d;
   logic        int_cmd_q, int_cmd_d, int_data_q, int_data_d;
   logic        eng_busy_s, eng_done_s, eng_timeout_s, eng_set_resp0_s, eng_set_long_s, eng_data_evt_s;
   logic [31:0] eng_resp0_s, eng_resp1_s;

   // Bus handshake and config register writes; status registers are only cleared, never written.
   always_comb begin
      req_s          = wb_cyc_i && wb_stb_i && !ack_q;
      wr_s           = req_s && wb_we_i;
      ack_d          = req_s;
      argument_d     = argument_q;
      command_d      = command_q;
      data_timeout_d = data_timeout_q;
      control_d      = control_q;
      cmd_timeout_d  = cmd_timeout_q;
      clock_div_d    = clock_div_q;
      soft_reset_d   = soft_reset_q;
      cmd_enable_d   = cmd_enable_q;
      data_enable_d  = data_enable_q;
      block_size_d   = block_size_q;
      block_count_d  = block_count_q;
      xfer_addr_d    = xfer_addr_q;
      cmd_clr_s      = 1'b0;
      data_clr_s     = 1'b0;
      if (wr_s) begin
         case (wb_adr_i)
            SDC_ARGUMENT:          argument_d     = reg_write(argument_q, wb_dat_i, wb_sel_i, MASK_32);
            SDC_COMMAND:           command_d      = reg_write(command_q, wb_dat_i, wb_sel_i, MASK_13);
            SDC_DATA_TIMEOUT:      data_timeout_d = reg_write(data_timeout_q, wb_dat_i, wb_sel_i, MASK_24);
            SDC_CONTROL:           control_d      = reg_write(control_q, wb_dat_i, wb_sel_i, MASK_1);
            SDC_CMD_TIMEOUT:       cmd_timeout_d  = reg_write(cmd_timeout_q, wb_dat_i, wb_sel_i, MASK_24);
            SDC_CLOCK_DIVIDER:     clock_div_d    = reg_write(clock_div_q, wb_dat_i, wb_sel_i, MASK_8);
            SDC_SOFT_RESET:        soft_reset_d   = reg_write(soft_reset_q, wb_dat_i, wb_sel_i, MASK_1);
            SDC_CMD_EVENT_ENABLE:  cmd_enable_d   = reg_write(cmd_enable_q, wb_dat_i, wb_sel_i, MASK_5);
            SDC_DATA_EVENT_ENABLE: data_enable_d  = reg_write(data_enable_q, wb_dat_i, wb_sel_i, MASK_5);
            SDC_BLOCK_SIZE:        block_size_d   = reg_write(block_size_q, wb_dat_i, wb_sel_i, MASK_12);
            SDC_BLOCK_COUNT:       block_count_d  = reg_write(block_count_q, wb_dat_i, wb_sel_i, MASK_16);
            SDC_DATA_XFER_ADDRESS: xfer_addr_d    = reg_write(xfer_addr_q, wb_dat_i, wb_sel_i, MASK_32);
            SDC_CMD_EVENT_STATUS:  cmd_clr_s      = 1'b1;
            SDC_DATA_EVENT_STATUS: data_clr_s     = 1'b1;
            default:               argument_d     = argument_q;
         endcase
      end else begin
         argument_d = argument_q;
      end
      launch_s = wr_s && (wb_adr_i == SDC_COMMAND) && !soft_reset_q[0];
   end

   always_comb begin
      case (wb_adr_i)
         SDC_ARGUMENT:          rdata_s = argument_q;
         SDC_COMMAND:           rdata_s = command_q;
         SDC_RESPONSE_0:        rdata_s = resp0_q;
         SDC_RESPONSE_1:        rdata_s = resp1_q;
         SDC_RESPONSE_2:        rdata_s = resp2_q;
         SDC_RESPONSE_3:        rdata_s = resp3_q;
         SDC_DATA_TIMEOUT:      rdata_s = data_timeout_q;
         SDC_CONTROL:           rdata_s = control_q;
         SDC_CMD_TIMEOUT:       rdata_s = cmd_timeout_q;
         SDC_CLOCK_DIVIDER:     rdata_s = clock_div_q;
         SDC_SOFT_RESET:        rdata_s = soft_reset_q;
         SDC_VOLTAGE:           rdata_s = VOLTAGE_VALUE;
         SDC_CAPABILITIES:      rdata_s = CAPS_VALUE;
         SDC_CMD_EVENT_STATUS:  rdata_s = {27'd0, cmd_status_q};
         SDC_CMD_EVENT_ENABLE:  rdata_s = cmd_enable_q;
         SDC_DATA_EVENT_STATUS: rdata_s = {27'd0, data_status_q};
         SDC_DATA_EVENT_ENABLE: rdata_s = data_enable_q;
         SDC_BLOCK_SIZE:        rdata_s = block_size_q;
         SDC_BLOCK_COUNT:       rdata_s = block_count_q;
         SDC_DATA_XFER_ADDRESS: rdata_s = xfer_addr_q;
         default:               rdata_s = 32'd0;
      endcase
      dat_sel_s = req_s;
      dat_d     = dat_sel_s ? rdata_s : 32'd0;
   end

   sdc_cmd_engine #(
      .CMD_LATENCY (CMD_LATENCY),
      .RSP_PATTERN (RSP_PATTERN)
   ) u_engine (
      .clk             (wb_clk_i),
      .rst_n           (wb_rst_n_i),
      .soft_rst_i      (soft_reset_q[0]),
      .launch_i        (launch_s),
      .arg_i           (argument_q),
      .index_i         (command_d[CMD_INDEX_MSB:CMD_INDEX_LSB]),
      .xfer_i          (command_d[CMD_XFER_MSB:CMD_XFER_LSB]),
      .rsp_i           (command_d[MMC_RSP_136:MMC_RSP_PRESENT]),
      .cmd_timeout_i   (cmd_timeout_q[23:0]),
      .busy_o          (eng_busy_s),
      .done_o          (eng_done_s),
      .timeout_o       (eng_timeout_s),
      .set_resp0_o     (eng_set_resp0_s),
      .set_resp_long_o (eng_set_long_s),
      .data_evt_o      (eng_data_evt_s),
      .resp0_o         (eng_resp0_s),
      .resp1_o         (eng_resp1_s)
   );

   // A completion posted on the same edge as a status clear survives the clear.
   always_comb begin
      cmd_status_d  = cmd_clr_s ? 5'd0 : cmd_status_q;
      data_status_d = data_clr_s ? 5'd0 : data_status_q;
      resp0_d       = resp0_q;
      resp1_d       = resp1_q;
      resp2_d       = resp2_q;
      resp3_d       = resp3_q;
      if (soft_reset_q[0]) begin
         cmd_status_d  = 5'd0;
         data_status_d = 5'd0;
      end else if (eng_done_s) begin
         if (eng_timeout_s) begin
            cmd_status_d[INT_CMD_EI]  = 1'b1;
            cmd_status_d[INT_CMD_CTE] = 1'b1;
         end else begin
            cmd_status_d[INT_CMD_CC] = 1'b1;
         end
         data_status_d[INT_DATA_EI] = data_status_d[INT_DATA_EI] | eng_data_evt_s;
         resp0_d = eng_set_resp0_s ? eng_resp0_s : resp0_q;
         resp1_d = eng_set_long_s ? eng_resp1_s : resp1_q;
         resp2_d = eng_set_long_s ? 32'd0 : resp2_q;
         resp3_d = eng_set_long_s ? 32'd0 : resp3_q;
      end else begin
         resp0_d = resp0_q;
      end
      int_cmd_d  = |(cmd_status_d & cmd_enable_d[4:0]);
      int_data_d = |(data_status_d & data_enable_d[4:0]);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         ack_q <= 1'b0;          dat_q <= 32'd0;
         argument_q <= 32'd0;    command_q <= 32'd0;     data_timeout_q <= 32'd0;
         control_q <= 32'd0;     cmd_timeout_q <= 32'd0; clock_div_q <= 32'd0;
         soft_reset_q <= 32'd0;  cmd_enable_q <= 32'd0;  data_enable_q <= 32'd0;
         block_size_q <= 32'd0;  block_count_q <= 32'd0; xfer_addr_q <= 32'd0;
         resp0_q <= 32'd0;       resp1_q <= 32'd0;       resp2_q <= 32'd0;       resp3_q <= 32'd0;
         cmd_status_q <= 5'd0;   data_status_q <= 5'd0;  int_cmd_q <= 1'b0;      int_data_q <= 1'b0;
      end else begin
         ack_q <= ack_d;              dat_q <= dat_d;
         argument_q <= argument_d;    command_q <= command_d;       data_timeout_q <= data_timeout_d;
         control_q <= control_d;      cmd_timeout_q <= cmd_timeout_d; clock_div_q <= clock_div_d;
         soft_reset_q <= soft_reset_d; cmd_enable_q <= cmd_enable_d; data_enable_q <= data_enable_d;
         block_size_q <= block_size_d; block_count_q <= block_count_d; xfer_addr_q <= xfer_addr_d;
         resp0_q <= resp0_d;          resp1_q <= resp1_d;           resp2_q <= resp2_d;  resp3_q <= resp3_d;
         cmd_status_q <= cmd_status_d; data_status_q <= data_status_d;
         int_cmd_q <= int_cmd_d;      int_data_q <= int_data_d;
      end
   end

   assign wb_ack_o   = ack_q;
   assign wb_dat_o   = dat_q;
   assign cmd_busy_o = eng_busy_s;
   assign int_cmd_o  = int_cmd_q;
   assign int_data_o = int_data_q;

endmodule

// File: tb/tb_sdc_wb_regs.sv
// Scenario bench for sdc_wb_regs: expected read data is queued when a read is issued
// and compared when the acknowledge arrives.
module tb_sdc_wb_regs;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  adr = 8'h00;
   logic [31:0] wdat = 32'd0;
   logic [31:0] rdat;
   logic [3:0]  sel = 4'h0;
   logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
   logic        ack, busy, int_cmd, int_data;
   int          checks = 0, errors = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   sdc_wb_regs dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wb_adr_i   (adr),
      .wb_dat_i   (wdat),
      .wb_dat_o   (rdat),
      .wb_sel_i   (sel),
      .wb_we_i    (we),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_ack_o   (ack),
      .cmd_busy_o (busy),
      .int_cmd_o  (int_cmd),
      .int_data_o (int_data)
   );

   // One transfer; returns read data and ack latency in cycles (0 = no ack).
   task automatic bus_xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output int lat);
      if (ack) begin
         @(posedge clk); #1;
      end
      adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
      lat = 0; r = 32'd0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            lat = i; r = rdat; break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL bus_timeout: adr %h no ack, required ack within 8 cycles", a);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] r; int lat;
      bus_xfer(a, 1'b1, d, 4'hF, r, lat);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] r, output int lat);
      bus_xfer(a, 1'b0, 32'd0, 4'hF, r, lat);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         n++; @(posedge clk); #1;
      end
      checks++;
      if (busy) begin errors++; $display("FAIL idle_timeout: busy %b required 0", busy); end
   endtask

   task automatic test_reset();
      logic [31:0] r, e; int lat;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ack, busy, int_cmd, int_data} !== 4'b0000) begin
         errors++; $display("FAIL reset_outs: got %b required 0000", {ack, busy, int_cmd, int_data});
      end
      checks++;
      if (rdat !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h required 0", rdat); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      wr(8'h18, 32'h0000_7FFF);
      sb_q.push_back(32'h0000_7FFF);
      rd(8'h18, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL dto_read: got %h required %h", r, e); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL ack_latency: got %0d required 1", lat); end
      sb_q.push_back(32'd0);
      rd(8'h1C, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL control_reset: got %h required %h", r, e); end
      sb_q.push_back(32'd3300);
      rd(8'h2C, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL voltage: got %h required %h", r, e); end
      wr(8'h18, 32'hFFFF_FFFF);
      sb_q.push_back(32'h00FF_FFFF);
      rd(8'h18, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL dto_width: got %h required %h", r, e); end
   endtask

   task automatic test_held_strobe();
      logic [3:0] pat;
      if (ack) begin @(posedge clk); #1; end
      adr = 8'h18; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pat[i] = ack;
      end
      cyc = 1'b0; stb = 1'b0;
      checks++;
      if (pat !== 4'b0101) begin errors++; $display("FAIL held_strobe: got %b required 0101", pat); end
   endtask

   task automatic test_cmd_basic();
      logic [31:0] r, e; int lat; int n;
      wr(8'h00, 32'd0);
      wr(8'h20, 32'h0000_FFFF);
      wr(8'h04, 32'h0000_0001);
      n = 0;
      while (busy && n < 200) begin
         n++; @(posedge clk); #1;
      end
      checks++;
      if (n != 64) begin errors++; $display("FAIL busy_cycles: got %0d required 64", n); end
      sb_q.push_back(32'h0000_0001);
      rd(8'h34, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL cmd0_status: got %h required %h", r, e); end
      sb_q.push_back(32'h0000_0900);
      rd(8'h08, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL cmd0_resp0: got %h required %h", r, e); end
      sb_q.push_back(32'd0);
      rd(8'h3C, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL cmd0_data_status: got %h required %h", r, e); end
   endtask

   task automatic test_timeout();
      logic [31:0] r, e; int lat;
      wr(8'h34, 32'd0);
      wr(8'h00, 32'h0000_0005);
      wr(8'h20, 32'h0000_0010);
      wr(8'h38, 32'h0000_0004);
      wr(8'h04, 32'h0000_0401);
      repeat (63) @(posedge clk);
      #1;
      checks++;
      if ({busy, int_cmd} !== 2'b10) begin
         errors++; $display("FAIL to_before: busy,int got %b required 10", {busy, int_cmd});
      end
      @(posedge clk); #1;
      checks++;
      if (int_cmd !== 1'b1) begin errors++; $display("FAIL to_irq: got %b required 1", int_cmd); end
      sb_q.push_back(32'h0000_0006);
      rd(8'h34, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL to_status: got %h required %h", r, e); end
      wr(8'h34, 32'd0);
      checks++;
      if (int_cmd !== 1'b0) begin errors++; $display("FAIL to_irq_clear: got %b required 0", int_cmd); end
      sb_q.push_back(32'd0);
      rd(8'h34, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL to_status_clear: got %h required %h", r, e); end
      sb_q.push_back(32'h0000_0900);
      rd(8'h08, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL to_resp0_kept: got %h required %h", r, e); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r, e; int lat;
      logic [7:0]  a_tbl[3] = '{8'h34, 8'h3C, 8'h04};
      logic [31:0] e_tbl[3] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0A81};
      wr(8'h20, 32'h0000_FFFF);
      wr(8'h38, 32'h0000_0001);
      wr(8'h40, 32'h0000_0002);
      wr(8'h34, 32'd0);
      wr(8'h3C, 32'd0);
      wr(8'h04, 32'h0000_0011);
      repeat (4) @(posedge clk);
      #1;
      wr(8'h04, 32'h0000_0A81);
      repeat (58) @(posedge clk);
      #1;
      checks++;
      if ({busy, int_cmd} !== 2'b10) begin
         errors++; $display("FAIL b2b_before: busy,int got %b required 10", {busy, int_cmd});
      end
      wr(8'h34, 32'd0);
      checks++;
      if ({busy, int_cmd, int_data} !== 3'b011) begin
         errors++; $display("FAIL b2b_post: busy,int_cmd,int_data got %b required 011", {busy, int_cmd, int_data});
      end
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(e_tbl[i]);
         rd(a_tbl[i], r, lat);
         e = sb_q.pop_front(); checks++;
         if (r !== e) begin errors++; $display("FAIL b2b_read_%h: got %h required %h", a_tbl[i], r, e); end
      end
      wr(8'h34, 32'd0);
      wr(8'h3C, 32'd0);
      repeat (80) @(posedge clk);
      #1;
      sb_q.push_back(32'd0);
      rd(8'h34, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL b2b_no_relaunch: got %h required %h", r, e); end
   endtask

   task automatic test_resp_long();
      logic [31:0] r, e; int lat;
      logic [7:0]  a_tbl[4] = '{8'h08, 8'h0C, 8'h10, 8'h14};
      logic [31:0] e_tbl[4] = '{32'h1234_5F78, 32'h0000_0002, 32'd0, 32'd0};
      wr(8'h00, 32'h1234_5678);
      wr(8'h04, 32'h0000_0103);
      wr(8'h00, 32'hFFFF_FFFF);
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(e_tbl[i]);
         rd(a_tbl[i], r, lat);
         e = sb_q.pop_front(); checks++;
         if (r !== e) begin errors++; $display("FAIL long_resp_%h: got %h required %h", a_tbl[i], r, e); end
      end
   endtask

   task automatic test_partial();
      logic [31:0] r, e; int lat;
      logic [31:0] r2; int lat2;
      bus_xfer(8'h60, 1'b1, 32'hAABB_CCDD, 4'b0010, r2, lat2);
      sb_q.push_back(32'h0000_CC00);
      rd(8'h60, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL partial_lane1: got %h required %h", r, e); end
      bus_xfer(8'h60, 1'b1, 32'h1122_3344, 4'b1000, r2, lat2);
      sb_q.push_back(32'h1100_CC00);
      rd(8'h60, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL partial_lane3: got %h required %h", r, e); end
      wr(8'h50, 32'hFFFF_FFFF);
      sb_q.push_back(32'd0);
      rd(8'h50, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e || lat != 1) begin
         errors++; $display("FAIL unmapped: got %h lat %0d required %h lat 1", r, lat, e);
      end
   endtask

   task automatic test_soft_reset();
      logic [31:0] r, e; int lat;
      sb_q.push_back(32'h0000_0001);
      rd(8'h34, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL srst_pre_status: got %h required %h", r, e); end
      wr(8'h04, 32'h0000_0001);
      wr(8'h28, 32'h0000_0001);
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL srst_abort: busy %b required 0", busy); end
      wr(8'h04, 32'h0000_0001);
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL srst_no_launch: busy %b required 0", busy); end
      sb_q.push_back(32'd0);
      rd(8'h34, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL srst_status: got %h required %h", r, e); end
      sb_q.push_back(32'h00FF_FFFF);
      rd(8'h18, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL srst_cfg_kept: got %h required %h", r, e); end
      wr(8'h28, 32'd0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] r, e; int lat;
      wr(8'h38, 32'h0000_0001);
      wr(8'h04, 32'h0000_0001);
      wait_idle();
      checks++;
      if (int_cmd !== 1'b1) begin errors++; $display("FAIL rmid_pre_irq: got %b required 1", int_cmd); end
      wr(8'h04, 32'h0000_0001);
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0; adr = 8'h34; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({ack, busy, int_cmd} !== 3'b000) begin
         errors++; $display("FAIL rmid_outs: ack,busy,int got %b required 000", {ack, busy, int_cmd});
      end
      cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
      repeat (70) @(posedge clk);
      #1;
      checks++;
      if ({busy, int_cmd} !== 2'b00) begin
         errors++; $display("FAIL rmid_after: busy,int got %b required 00", {busy, int_cmd});
      end
      sb_q.push_back(32'd0);
      rd(8'h34, r, lat);
      e = sb_q.pop_front(); checks++;
      if (r !== e) begin errors++; $display("FAIL rmid_status: got %h required %h", r, e); end
   endtask

   initial begin
      test_reset();
      test_held_strobe();
      test_cmd_basic();
      test_timeout();
      test_back_to_back();
      test_resp_long();
      test_partial();
      test_soft_reset();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
